// File: rtl/wb_stream_dma_if.sv
// Wishbone initiator and AXI-Stream bundle used by wb_stream_dma.
// The master modport is the DMA's view; slave is the memory/stream side.
interface wb_stream_dma_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready
  );
endinterface

// File: rtl/wb_stream_dma.sv
// Single-outstanding Wishbone DMA moving word blocks between memory and
// an AXI-Stream master (MM2S, dir=0) or slave (S2MM, dir=1).
module wb_stream_dma #(
  parameter int TIMEOUT = 64,
  parameter int LEN_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             dir,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             early_last,
  wb_stream_dma_if.master  bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, PUSH, PULL, DONE, ERR} state_t;

  state_t           state, state_nxt;
  logic [31:0]      addr;
  logic [31:0]      data;
  logic [LEN_W-1:0] remaining;
  logic [TO_W-1:0]  to_cnt;
  logic             dir_q;
  logic             last_seen;
  logic             early_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // One shared data register: read data on its way to the stream in MM2S,
  // stream data on its way to the bus in S2MM.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      addr      <= '0;
      data      <= '0;
      remaining <= '0;
      to_cnt    <= '0;
      dir_q     <= 1'b0;
      last_seen <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr      <= base_addr;
          remaining <= len;
          dir_q     <= dir;
          to_cnt    <= '0;
          last_seen <= 1'b0;
          early_q   <= 1'b0;
        end
        REQ: begin
          if (bus.wbm_ack_i) begin
            addr      <= addr + 32'd4;
            remaining <= remaining - 1'b1;
            to_cnt    <= '0;
            if (!dir_q) data <= bus.wbm_dat_i;
          end else if (to_cnt == TO_LAST) begin
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        PULL: if (bus.s_axis_tvalid) begin
          data <= bus.s_axis_tdata;
          if (bus.s_axis_tlast && remaining > LEN_W'(1)) begin
            last_seen <= 1'b1;
            early_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Remaining is compared before its decrement, so 1 means "this was the last word".
  always_comb begin
    state_nxt         = state;
    bus.wbm_cyc_o     = 1'b0;
    bus.wbm_stb_o     = 1'b0;
    bus.wbm_we_o      = 1'b0;
    bus.wbm_sel_o     = 4'h0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    bus.s_axis_tready = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (len == '0) state_nxt = DONE;
        else if (dir)  state_nxt = PULL;
        else           state_nxt = REQ;
      end
      REQ: begin
        bus.wbm_cyc_o = 1'b1;
        bus.wbm_stb_o = 1'b1;
        bus.wbm_we_o  = dir_q;
        bus.wbm_sel_o = 4'hF;
        if (bus.wbm_ack_i) begin
          if (!dir_q)                                     state_nxt = PUSH;
          else if (remaining == LEN_W'(1) || last_seen)   state_nxt = DONE;
          else                                            state_nxt = PULL;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = ERR;
        end
      end
      PUSH: begin
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tlast  = (remaining == '0);
        if (bus.m_axis_tready) state_nxt = (remaining == '0) ? DONE : REQ;
      end
      PULL: begin
        bus.s_axis_tready = 1'b1;
        if (bus.s_axis_tvalid) state_nxt = REQ;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.wbm_adr_o    = addr;
  assign bus.wbm_dat_o    = data;
  assign bus.m_axis_tdata = data;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign error            = (state == ERR);
  assign early_last       = early_q;

endmodule

// File: tb/tb_wb_stream_dma.sv
// Randomized bench for wb_stream_dma: a Wishbone memory and stream endpoints
// are modelled per cycle, and results are checked against expected block transfers.
module tb_wb_stream_dma;
  localparam int TIMEOUT = 64;
  localparam int LEN_W   = 16;
  localparam int BUDGET  = 3000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             dir;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] len;
  logic             busy, done, error, early_last;

  wb_stream_dma_if bus();

  wb_stream_dma #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .dir(dir),
    .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .error(error), .early_last(early_last), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } acc_t;

  int          n_compared = 0;
  int          n_mismatched = 0;
  acc_t        obs_acc[$];
  logic [32:0] obs_stream[$];
  logic [31:0] mem [bit [31:0]];
  logic [31:0] s_words[$];
  int          s_last_pos, s_idx, ack_delay, wcnt, tready_mode, cycle;
  int          done_cnt, err_cnt, cyc_cnt, stab_err, overlap;
  bit          never_ack, s_hs_pend, stall_prev;
  logic [31:0] stall_data;

  function automatic logic [31:0] mem_read(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'd3 + 32'h0BAD_0007;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then play memory, sink and source for that cycle.
  task automatic step_cycle();
    acc_t a;
    @(negedge clk);
    cycle++;
    if (bus.wbm_ack_i) begin
      bus.wbm_ack_i = 1'b0;
    end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !never_ack) begin
      if (wcnt >= ack_delay) begin
        wcnt = 0;
        bus.wbm_ack_i = 1'b1;
        if (bus.wbm_we_o) mem[bus.wbm_adr_o] = bus.wbm_dat_o;
        else              bus.wbm_dat_i = mem_read(bus.wbm_adr_o);
        a.adr = bus.wbm_adr_o; a.we = bus.wbm_we_o;
        a.sel = bus.wbm_sel_o; a.dat = bus.wbm_dat_o;
        obs_acc.push_back(a);
      end else begin
        wcnt++;
      end
    end else if (!bus.wbm_cyc_o) begin
      wcnt = 0;
    end

    case (tready_mode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = 1'($urandom_range(0, 1));
      default: bus.m_axis_tready = 1'(((cycle / 2) % 2) != 0);
    endcase
    if (stall_prev && (!bus.m_axis_tvalid || bus.m_axis_tdata !== stall_data)) stab_err++;
    if (bus.m_axis_tvalid && bus.wbm_cyc_o) overlap++;
    if (bus.m_axis_tvalid && bus.m_axis_tready)
      obs_stream.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
    stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
    stall_data = bus.m_axis_tdata;

    if (s_hs_pend) s_idx++;
    if (!bus.s_axis_tvalid || s_hs_pend) begin
      if (s_idx < s_words.size() && $urandom_range(0, 3) != 0) begin
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = s_words[s_idx];
        bus.s_axis_tlast  = (s_idx == s_last_pos);
      end else begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
      end
    end
    s_hs_pend = bus.s_axis_tvalid && bus.s_axis_tready;

    if (done)          done_cnt++;
    if (error)         err_cnt++;
    if (bus.wbm_cyc_o) cyc_cnt++;
  endtask

  task automatic clear_obs();
    obs_acc.delete(); obs_stream.delete(); s_words.delete();
    done_cnt = 0; err_cnt = 0; cyc_cnt = 0; stab_err = 0; overlap = 0;
    s_idx = 0; s_hs_pend = 1'b0; stall_prev = 1'b0; wcnt = 0;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
  endtask

  // One block transfer; expectations come from base + 4*i addressing and the tlast rule.
  task automatic applyStimulus(input bit d, input logic [31:0] base, input int n,
                               input int last_pos, input int delay, input int trmode,
                               input bit no_ack, input bit poke, input int first_word);
    int  guard, k;
    bit  exp_early;
    logic [31:0] ea;
    clear_obs();
    ack_delay = delay; tready_mode = trmode; never_ack = no_ack; s_last_pos = last_pos;
    if (d) for (int i = 0; i < n; i++)
      s_words.push_back(first_word >= 0 ? 32'(first_word + i) : $urandom);
    dir = d; base_addr = base; len = LEN_W'(n); start = 1'b1;
    step_cycle();
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("early_clr_on_start", 32'(early_last), 32'd0);
    guard = 0;
    while (done_cnt == 0 && err_cnt == 0 && guard < BUDGET) begin
      if (poke && guard == 2 && busy) begin
        start = 1'b1; dir = ~d; base_addr = 32'h1234_5670; len = LEN_W'(7);
      end else begin
        start = 1'b0;
      end
      step_cycle();
      guard++;
    end
    start = 1'b0;
    checkOutput("finish_in_budget", 32'(guard < BUDGET), 32'd1);
    step_cycle();
    checkOutput("busy_end", 32'(busy), 32'd0);
    checkOutput("pulse_one_cycle", 32'(done | error), 32'd0);
    if (no_ack) begin
      checkOutput("err_pulse", 32'(err_cnt), 32'd1);
      checkOutput("no_done", 32'(done_cnt), 32'd0);
      checkOutput("req_cycles", 32'(cyc_cnt), 32'(TIMEOUT));
      checkOutput("no_access", 32'(obs_acc.size()), 32'd0);
    end else begin
      exp_early = d && last_pos >= 0 && last_pos < n - 1;
      k = exp_early ? last_pos + 1 : n;
      checkOutput("done_pulse", 32'(done_cnt), 32'd1);
      checkOutput("no_error", 32'(err_cnt), 32'd0);
      checkOutput("early_last", 32'(early_last), 32'(exp_early));
      checkOutput("acc_count", 32'(obs_acc.size()), 32'(k));
      for (int i = 0; i < k && i < obs_acc.size(); i++) begin
        ea = base + 32'(4 * i);
        checkOutput("acc_adr", obs_acc[i].adr, ea);
        checkOutput("acc_we", 32'(obs_acc[i].we), 32'(d));
        checkOutput("acc_sel", 32'(obs_acc[i].sel), 32'hF);
        if (d) checkOutput("acc_wdata", obs_acc[i].dat, s_words[i]);
      end
      if (!d) begin
        checkOutput("beat_count", 32'(obs_stream.size()), 32'(n));
        for (int i = 0; i < n && i < obs_stream.size(); i++) begin
          checkOutput("beat_data", obs_stream[i][31:0], mem_read(base + 32'(4 * i)));
          checkOutput("beat_last", 32'(obs_stream[i][32]), 32'(i == n - 1));
        end
      end else begin
        checkOutput("beat_count", 32'(obs_stream.size()), 32'd0);
      end
      checkOutput("hold_stable", 32'(stab_err), 32'd0);
      checkOutput("no_bus_while_push", 32'(overlap), 32'd0);
      if (n == 0) begin
        checkOutput("len0_no_cyc", 32'(cyc_cnt), 32'd0);
        checkOutput("len0_latency", 32'(guard <= 1), 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; len = '0;
    bus.wbm_dat_i = '0; bus.wbm_ack_i = 1'b0; bus.m_axis_tready = 1'b0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    cycle = 0; ack_delay = 0; tready_mode = 0; never_ack = 1'b0; s_last_pos = -1;
    clear_obs();
    repeat (3) step_cycle();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_early", 32'(early_last), 32'd0);
    checkOutput("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    checkOutput("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    checkOutput("rst_tready", 32'(bus.s_axis_tready), 32'd0);
    rst = 1'b0;
    step_cycle();

    $display("[TB] directed MM2S");
    for (int i = 0; i < 4; i++) mem[32'h3800_0000 + 32'(4 * i)] = 32'(i + 1);
    applyStimulus(1'b0, 32'h3800_0000, 4, -1, 10, 0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 3; i++) mem[32'h3800_0100 + 32'(4 * i)] = 32'(i + 1);
    applyStimulus(1'b0, 32'h3800_0100, 3, -1, 2, 2, 1'b0, 1'b0, -1);

    $display("[TB] directed S2MM");
    applyStimulus(1'b1, 32'h3000_0080, 5, 4, 1, 0, 1'b0, 1'b0, 10);
    applyStimulus(1'b1, 32'h3000_0200, 8, 2, 1, 0, 1'b0, 1'b0, 100);
    repeat (5) step_cycle();
    checkOutput("early_sticky", 32'(early_last), 32'd1);
    applyStimulus(1'b1, 32'h3000_0400, 4, -1, 0, 0, 1'b0, 1'b1, 50);

    $display("[TB] timeout, len0, wrap");
    applyStimulus(1'b0, 32'h3800_0000, 2, -1, 0, 0, 1'b1, 1'b0, -1);
    applyStimulus(1'b0, 32'h3000_0000, 0, -1, 0, 0, 1'b0, 1'b0, -1);
    applyStimulus(1'b0, 32'hFFFF_FFF8, 4, -1, 0, 1, 1'b0, 1'b0, -1);

    $display("[TB] reset mid-REQ");
    clear_obs();
    ack_delay = 20; never_ack = 1'b0; tready_mode = 0;
    dir = 1'b0; base_addr = 32'h3800_0000; len = LEN_W'(3); start = 1'b1;
    step_cycle();
    start = 1'b0;
    repeat (3) step_cycle();
    checkOutput("cyc_before_rst", 32'(bus.wbm_cyc_o), 32'd1);
    rst = 1'b1;
    step_cycle();
    checkOutput("rst_mid_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    checkOutput("rst_mid_stb", 32'(bus.wbm_stb_o), 32'd0);
    checkOutput("rst_mid_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step_cycle();

    $display("[TB] randomized transfers");
    for (int t = 0; t < 24; t++) begin
      bit          d;
      int          n, lp;
      logic [31:0] b;
      d  = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 6));
      b  = (t % 6 == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      lp = -1;
      if (d && $urandom_range(0, 2) != 0) lp = int'($urandom_range(0, n - 1));
      applyStimulus(d, b, n, lp, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                    1'b0, (t % 4) == 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
